onehot_seq_encoder: RTL

//  Inverse of the team's 3-to-8 decoder: accepts an 8-bit request vector and

---
 rtl/onehot_seq_encoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/onehot_seq_encoder.sv
// onehot_seq_encoder
//   Serial multi-hot encoder. Accepts a request vector over a valid/ready
//   handshake and emits the index of each set bit as one beat per handshake.
//   By default it emits the lowest set bit first.
//
//   Build option: define ENC_MSB_FIRST_EN to emit the highest set bit first.
//   The out_last rule is the same in both builds.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   synchronous reset, active-low
//   in_valid   in   upstream vector valid
//   in_ready   out  vector can be accepted this cycle
//   in_vec     in   request vector, sampled on in_valid && in_ready
//   out_valid  out  out_idx is valid
//   out_ready  in   downstream accepts out_idx
//   out_idx    out  index of the currently selected set bit
//   out_last   out  final beat of the current vector
//   busy       out  pending bits remain
//
// FSM states
//   state   | meaning
//   S_IDLE  | nothing pending, ready for a new vector
//   S_DRAIN | emitting one index per accepted beat from pending
module onehot_seq_encoder #(
  parameter int IN_W  = 8,
  parameter int IDX_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IN_W-1:0]   pending;
  logic [IN_W-1:0]   pending_nxt;
  logic [IDX_W-1:0]  sel_idx;
  logic              single;
  logic              beat;
  logic              accept;

  // Scan direction sets emission order. The last match in the loop wins,
  // so the loop runs opposite to the desired priority.
  always_comb begin
    sel_idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < IN_W; i++) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
`else
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
`endif
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign single    = (pending != '0) && ((pending & (pending - IN_W'(1))) == '0);

  assign out_valid = (state == S_DRAIN);
  assign out_idx   = sel_idx;
  assign out_last  = out_valid && single;
  assign busy      = (pending != '0);

  assign beat      = out_valid && out_ready;
  // Opening in_ready on the accepted last beat lets the next vector follow
  // without a bubble.
  assign in_ready  = (state == S_IDLE) || (beat && single);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      S_IDLE: begin
        // An all-zero vector is consumed and dropped.
        if (accept && (in_vec != '0)) begin
          pending_nxt = in_vec;
          state_nxt   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (beat) begin
          if (single) begin
            if (accept && (in_vec != '0)) begin
              pending_nxt = in_vec;
            end else begin
              pending_nxt = '0;
              state_nxt   = S_IDLE;
            end
          end else begin
            pending_nxt = pending & ~(IN_W'(1) << sel_idx);
          end
        end
      end
      default: begin
        pending_nxt = '0;
        state_nxt   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

endmodule
